// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb
//  Purpose  : Merges NUM_CH request/response master channels onto a single
//             downstream memory port. Round-robin or fixed-priority grant,
//             one outstanding transaction, optional response timeout that
//             completes the transaction with an error flag.
//  Ports    : clock, reset            - clock / sync active-high reset
//             io_ch_*  (in)           - flattened per-channel requests
//             io_ch_respValid/Err/rdata (out) - completion to granted channel
//             io_mem_* (out)          - registered copy of granted request
//             io_mem_respValid/rdata (in) - downstream completion
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            io_ch_reqValid,
    input  logic [NUM_CH*ADDR_W-1:0]     io_ch_addr,
    input  logic [NUM_CH*2-1:0]          io_ch_size,
    input  logic [NUM_CH-1:0]            io_ch_wen,
    input  logic [NUM_CH*DATA_W-1:0]     io_ch_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0]   io_ch_wmask,
    output logic [NUM_CH-1:0]            io_ch_respValid,
    output logic                         io_ch_respErr,
    output logic [DATA_W-1:0]            io_ch_rdata,
    output logic                         io_mem_reqValid,
    output logic [ADDR_W-1:0]            io_mem_addr,
    output logic [1:0]                   io_mem_size,
    output logic                         io_mem_wen,
    output logic [DATA_W-1:0]            io_mem_wdata,
    output logic [DATA_W/8-1:0]          io_mem_wmask,
    input  logic                         io_mem_respValid,
    input  logic [DATA_W-1:0]            io_mem_rdata
);

    localparam int c_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_MASK_W = DATA_W / 8;
    localparam int c_CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST =
        (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_IDX_W-1:0]    r_last;
    logic [c_IDX_W-1:0]    r_grant;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [1:0]            r_size;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_MASK_W-1:0]   r_wmask;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;

    logic                  w_found;
    logic [c_IDX_W-1:0]    w_win;
    logic                  w_tmo;
    logic                  w_busy;
    logic                  w_resp;

    // ------------------------------------------------------------------
    // Winner selection. Round-robin scans from last_grant+1 with a single
    // wrap subtraction (sum never exceeds 2*NUM_CH-1); fixed priority
    // scans from index 0.
    // ------------------------------------------------------------------
    always_comb begin
        logic [c_IDX_W:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 1) begin
                v_idx = (c_IDX_W+1)'(i);
            end else begin
                v_idx = {1'b0, r_last} + (c_IDX_W+1)'(1) + (c_IDX_W+1)'(i);
                if (v_idx >= (c_IDX_W+1)'(NUM_CH)) begin
                    v_idx = v_idx - (c_IDX_W+1)'(NUM_CH);
                end
            end
            if (!w_found && io_ch_reqValid[v_idx[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[c_IDX_W-1:0];
            end
        end
    end

    assign w_tmo  = (TIMEOUT != 0) && (r_cnt == c_TMO_LAST);
    assign w_busy = (r_state == S_BUSY);
    assign w_resp = (r_state == S_RESP);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_found) w_next = S_BUSY;
            S_BUSY: if (io_mem_respValid || w_tmo) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, timeout counter, response capture.
    // A response in the final timeout cycle takes precedence over the
    // timeout, so real data is never discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last  <= c_IDX_W'(NUM_CH - 1);
            r_grant <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        if (ARB_MODE == 0) begin
                            r_last <= w_win;
                        end
                        r_cnt   <= '0;
                        r_addr  <= io_ch_addr [w_win*ADDR_W   +: ADDR_W];
                        r_size  <= io_ch_size [w_win*2        +: 2];
                        r_wen   <= io_ch_wen  [w_win];
                        r_wdata <= io_ch_wdata[w_win*DATA_W   +: DATA_W];
                        r_wmask <= io_ch_wmask[w_win*c_MASK_W +: c_MASK_W];
                    end
                end
                S_BUSY: begin
                    // Saturating count; never wraps back into range.
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (io_mem_respValid) begin
                        r_rdata <= io_mem_rdata;
                        r_err   <= 1'b0;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded only from state and latched registers.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_resp
            assign io_ch_respValid[g] = w_resp && (r_grant == c_IDX_W'(g));
        end
    endgenerate

    assign io_ch_respErr   = w_resp && r_err;
    assign io_ch_rdata     = w_resp ? r_rdata : '0;
    assign io_mem_reqValid = w_busy;
    assign io_mem_addr     = w_busy ? r_addr  : '0;
    assign io_mem_size     = w_busy ? r_size  : '0;
    assign io_mem_wen      = w_busy && r_wen;
    assign io_mem_wdata    = w_busy ? r_wdata : '0;
    assign io_mem_wmask    = w_busy ? r_wmask : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arb
//  Purpose  : Directed self-checking bench for mem_arb. Instance A is
//             round-robin with TIMEOUT=8; instance B is fixed priority with
//             an always-immediate downstream responder. Stimulus is driven
//             and outputs sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ch_req;
    logic [63:0] ch_addr;
    logic [3:0]  ch_size;
    logic [1:0]  ch_wen;
    logic [63:0] ch_wdata;
    logic [7:0]  ch_wmask;

    logic        auto_a;
    logic        mem_resp_a;
    logic [31:0] mem_rdata_a;

    logic [1:0]  a_resp;
    logic        a_err;
    logic [31:0] a_rdata;
    logic        a_mreq;
    logic [31:0] a_maddr;
    logic [1:0]  a_msize;
    logic        a_mwen;
    logic [31:0] a_mwdata;
    logic [3:0]  a_mwmask;
    logic        a_mresp;

    logic [1:0]  b_resp;
    logic        b_err;
    logic [31:0] b_rdata;
    logic        b_mreq;
    logic [31:0] b_maddr;
    logic [1:0]  b_msize;
    logic        b_mwen;
    logic [31:0] b_mwdata;
    logic [3:0]  b_mwmask;
    logic        b_mresp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign a_mresp = auto_a ? a_mreq : mem_resp_a;
    assign b_mresp = b_mreq;

    mem_arb #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(8)) u_dut_a (
        .clock(clock), .reset(reset),
        .io_ch_reqValid(ch_req), .io_ch_addr(ch_addr), .io_ch_size(ch_size),
        .io_ch_wen(ch_wen), .io_ch_wdata(ch_wdata), .io_ch_wmask(ch_wmask),
        .io_ch_respValid(a_resp), .io_ch_respErr(a_err), .io_ch_rdata(a_rdata),
        .io_mem_reqValid(a_mreq), .io_mem_addr(a_maddr), .io_mem_size(a_msize),
        .io_mem_wen(a_mwen), .io_mem_wdata(a_mwdata), .io_mem_wmask(a_mwmask),
        .io_mem_respValid(a_mresp), .io_mem_rdata(mem_rdata_a)
    );

    mem_arb #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(8)) u_dut_b (
        .clock(clock), .reset(reset),
        .io_ch_reqValid(ch_req), .io_ch_addr(ch_addr), .io_ch_size(ch_size),
        .io_ch_wen(ch_wen), .io_ch_wdata(ch_wdata), .io_ch_wmask(ch_wmask),
        .io_ch_respValid(b_resp), .io_ch_respErr(b_err), .io_ch_rdata(b_rdata),
        .io_mem_reqValid(b_mreq), .io_mem_addr(b_maddr), .io_mem_size(b_msize),
        .io_mem_wen(b_mwen), .io_mem_wdata(b_mwdata), .io_mem_wmask(b_mwmask),
        .io_mem_respValid(b_mresp), .io_mem_rdata(32'h0000_0055)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk_quiet_a(input string tag);
        chk({tag, "_resp"},  a_resp,  2'b00);
        chk({tag, "_err"},   a_err,   1'b0);
        chk({tag, "_rdata"}, a_rdata, 32'h0);
        chk({tag, "_mreq"},  a_mreq,  1'b0);
        chk({tag, "_mfields"}, {a_maddr, a_msize, a_mwen, a_mwdata, a_mwmask}, 71'h0);
    endtask

    initial begin
        reset       = 1'b1;
        ch_req      = '0;
        ch_addr     = '0;
        ch_size     = '0;
        ch_wen      = '0;
        ch_wdata    = '0;
        ch_wmask    = '0;
        auto_a      = 1'b0;
        mem_resp_a  = 1'b0;
        mem_rdata_a = '0;

        // Reset state
        tick(); tick();
        chk_quiet_a("reset");
        chk("reset_b_resp", {b_resp, b_mreq}, 3'b000);
        reset = 1'b0;
        tick();

        // Round-robin (A) vs fixed priority (B), immediate responses
        auto_a  = 1'b1;
        ch_addr = {32'h2000_0000, 32'h1000_0000};
        ch_req  = 2'b11;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k % 3 == 2) begin
                chk("rr_a_resp", a_resp, ((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
                chk("fp_b_resp", b_resp, 2'b01);
                chk("fp_b_err_rdata", {b_err, b_rdata}, {1'b0, 32'h0000_0055});
            end else begin
                chk("rr_a_resp_idle", a_resp, 2'b00);
                chk("fp_b_resp_idle", b_resp, 2'b00);
            end
            if (k % 3 == 1) begin
                chk("fp_b_mfields", {b_mreq, b_maddr, b_msize, b_mwen, b_mwdata, b_mwmask},
                    {1'b1, 32'h1000_0000, 2'd0, 1'b0, 32'h0, 4'h0});
            end
            if (k == 11) ch_req = 2'b00;
        end
        tick();
        auto_a = 1'b0;
        tick();

        // Single read, response two cycles after reqValid
        ch_addr[31:0] = 32'h8000_0000;
        ch_size[1:0]  = 2'd2;
        ch_req        = 2'b01;
        tick();
        chk("rd_mreq", a_mreq, 1'b1);
        chk("rd_maddr", a_maddr, 32'h8000_0000);
        chk("rd_msize", a_msize, 2'd2);
        tick();
        chk("rd_resp_t2", a_resp, 2'b00);
        tick();
        chk("rd_resp_t3", a_resp, 2'b00);
        mem_resp_a  = 1'b1;
        mem_rdata_a = 32'hDEAD_BEEF;
        tick();
        mem_resp_a  = 1'b0;
        mem_rdata_a = '0;
        chk("rd_resp", a_resp, 2'b01);
        chk("rd_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("rd_err", a_err, 1'b0);
        ch_req = 2'b00;
        tick();
        chk_quiet_a("rd_after");

        // Write passthrough on channel 1
        ch_addr[63:32]  = 32'h0000_0104;
        ch_wdata[63:32] = 32'h1122_3344;
        ch_wmask[7:4]   = 4'b1100;
        ch_size[3:2]    = 2'd1;
        ch_wen[1]       = 1'b1;
        ch_req          = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("wr_mfields", {a_mreq, a_maddr, a_msize, a_mwen, a_mwdata, a_mwmask},
                {1'b1, 32'h0000_0104, 2'd1, 1'b1, 32'h1122_3344, 4'b1100});
            if (k == 3) mem_resp_a = 1'b1;
        end
        tick();
        mem_resp_a = 1'b0;
        chk("wr_resp", {a_resp, a_err}, {2'b10, 1'b0});
        ch_req = 2'b00;
        ch_wen = 2'b00;
        tick();

        // Timeout: no response for 8 BUSY cycles
        mem_rdata_a = 32'hFFFF_FFFF;
        ch_req      = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_busy", {a_mreq, a_resp}, {1'b1, 2'b00});
        end
        tick();
        chk("to_resp", a_resp, 2'b01);
        chk("to_err", a_err, 1'b1);
        chk("to_rdata", a_rdata, 32'h0);
        ch_req = 2'b00;
        tick();
        mem_resp_a = 1'b1;
        chk("to_idle_resp", a_resp, 2'b00);
        tick();
        mem_resp_a = 1'b0;
        chk("late_ignored", {a_mreq, a_resp}, 3'b000);
        mem_rdata_a = 32'h1234_5678;
        ch_req      = 2'b01;
        tick();
        chk("post_to_mreq", a_mreq, 1'b1);
        mem_resp_a = 1'b1;
        tick();
        mem_resp_a = 1'b0;
        chk("post_to_resp", {a_resp, a_err, a_rdata}, {2'b01, 1'b0, 32'h1234_5678});
        ch_req = 2'b00;
        tick();

        // Response arrives on the final timeout count
        mem_rdata_a = 32'hCAFE_F00D;
        ch_req      = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) mem_resp_a = 1'b1;
        end
        tick();
        mem_resp_a = 1'b0;
        chk("sim_resp", {a_resp, a_err, a_rdata}, {2'b01, 1'b0, 32'hCAFE_F00D});
        ch_req = 2'b00;
        tick();

        // Reset mid-BUSY; last grant was ch0, so only reset makes ch0 win next
        ch_addr = {32'h2000_0000, 32'h1000_0000};
        ch_req  = 2'b01;
        tick();
        chk("rst_busy_mreq", a_mreq, 1'b1);
        reset  = 1'b1;
        ch_req = 2'b11;
        tick();
        chk_quiet_a("rst_mid");
        reset = 1'b0;
        tick();
        chk("rst_grant", {a_mreq, a_maddr, a_resp}, {1'b1, 32'h1000_0000, 2'b00});
        mem_resp_a = 1'b1;
        tick();
        mem_resp_a = 1'b0;
        chk("rst_resp", a_resp, 2'b01);
        ch_req = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
